// File: rtl/fb_glyph_sched.sv
`default_nettype none
// ============================================================================
// Module   : fb_glyph_sched
// Purpose  : Schedules redraws of NUM_DIGITS hex glyphs into a byte-wide
//            framebuffer. Each digit keeps a shadow of the value last drawn
//            plus a pending flag; dirty digits are served round-robin, one
//            glyph row per ADDR/WRITE pair, reading a synchronous font ROM.
// Ports    : clk        - clock, all state changes on the rising edge
//            rst        - asynchronous active-high reset
//            digit_val  - packed hex values, digit i at [4i+3:4i]
//            force_all  - level request to redraw every digit
//            rom_addr   - font ROM address (glyph*ROWS + row)
//            rom_data   - font ROM byte, valid the cycle after rom_addr
//            fb_we      - framebuffer byte write strobe
//            fb_waddr   - framebuffer byte address
//            fb_wdata   - framebuffer byte data
//            busy       - high while a digit pass is in progress
//            frame_done - one-cycle pulse when the schedule drains to idle
// Revision : 1.0 - initial release
// ============================================================================
module fb_glyph_sched #(
  parameter int NUM_DIGITS = 4,
  parameter int ROWS       = 16,
  parameter int STRIDE     = 40,
  parameter int FB_BASE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  input  logic                    force_all,
  output logic [7:0]              rom_addr,
  input  logic [7:0]              rom_data,
  output logic                    fb_we,
  output logic [15:0]             fb_waddr,
  output logic [7:0]              fb_wdata,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [ROW_W-1:0] c_LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [SEL_W-1:0] c_LAST_DIG  = SEL_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ADDR  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  logic [SEL_W-1:0]        r_sel;        // digit currently being drawn
  logic [SEL_W-1:0]        r_rr_ptr;     // round-robin search start
  logic [ROW_W-1:0]        r_row;
  logic [3:0]              r_glyph;      // glyph frozen for the whole pass
  logic [4*NUM_DIGITS-1:0] r_shadow;     // value last latched per digit
  logic [NUM_DIGITS-1:0]   r_pending;
  logic [7:0]              r_rom_hold;   // rom_addr value outside ADDR
  logic                    r_frame_done;

  logic [NUM_DIGITS-1:0]   w_dirty;
  logic                    w_any_dirty;
  logic                    w_found;
  logic [SEL_W-1:0]        w_pick;
  logic [SEL_W-1:0]        w_idx;
  logic [3:0]              w_pick_val;
  logic [SEL_W-1:0]        w_sel_inc;
  logic [7:0]              w_rom_addr;

  // --------------------------------------------------------------------------
  // Dirty tracking: a digit needs drawing if it was explicitly requested or
  // its live value differs from what was last drawn.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dirty
      assign w_dirty[gi] = r_pending[gi] |
                           (digit_val[4*gi +: 4] != r_shadow[4*gi +: 4]);
    end
  endgenerate

  assign w_any_dirty = |w_dirty;

  // --------------------------------------------------------------------------
  // Round-robin pick. Walking the offsets from the far end back toward zero
  // leaves the closest dirty digit at or after r_rr_ptr as the final winner.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_idx = SEL_W'((int'(r_rr_ptr) + k) % NUM_DIGITS);
      if (w_dirty[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Value of the picked digit, captured into glyph and shadow during SCAN.
  always_comb begin
    w_pick_val = '0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (w_pick == SEL_W'(j)) begin
        w_pick_val = digit_val[4*j +: 4];
      end
    end
  end

  assign w_sel_inc  = (r_sel == c_LAST_DIG) ? '0 : r_sel + 1'b1;

  // Truncation to the 8-bit ROM address space is intentional.
  assign w_rom_addr = 8'(int'(r_glyph) * ROWS + int'(r_row));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_any_dirty) begin
          w_next = SCAN;
        end
      end
      SCAN: begin
        // A digit can stop being dirty between IDLE and SCAN if its value
        // reverts to the shadow; fall back to idle in that case.
        w_next = w_found ? ADDR : IDLE;
      end
      ADDR: begin
        w_next = WRITE;
      end
      WRITE: begin
        if (r_row != c_LAST_ROW) begin
          w_next = ADDR;
        end else if (w_any_dirty) begin
          w_next = SCAN;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_rr_ptr     <= '0;
      r_row        <= '0;
      r_glyph      <= '0;
      r_shadow     <= '0;
      r_pending    <= '1;
      r_rom_hold   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= (r_state != IDLE) && (w_next == IDLE);

      case (r_state)
        SCAN: begin
          if (w_found) begin
            r_sel   <= w_pick;
            r_glyph <= w_pick_val;
            r_row   <= '0;
            for (int j = 0; j < NUM_DIGITS; j++) begin
              if (w_pick == SEL_W'(j)) begin
                r_shadow[4*j +: 4] <= w_pick_val;
              end
            end
          end
        end
        ADDR: begin
          r_rom_hold <= w_rom_addr;
        end
        WRITE: begin
          if (r_row != c_LAST_ROW) begin
            r_row <= r_row + 1'b1;
          end else begin
            r_rr_ptr <= w_sel_inc;
          end
        end
        default: begin
        end
      endcase

      // A force request in the same cycle as the SCAN clear takes priority.
      if (force_all) begin
        r_pending <= '1;
      end else if ((r_state == SCAN) && w_found) begin
        r_pending[w_pick] <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The ROM registers its address at the end of ADDR, so the data it returns
  // lines up with the WRITE cycle that follows.
  assign rom_addr   = (r_state == ADDR) ? w_rom_addr : r_rom_hold;
  assign fb_we      = (r_state == WRITE);
  assign fb_waddr   = fb_we ? 16'(FB_BASE + int'(r_sel) * 2 + int'(r_row) * STRIDE)
                            : '0;
  assign fb_wdata   = fb_we ? rom_data : '0;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_fb_glyph_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_glyph_sched
// Purpose  : Self-checking bench for fb_glyph_sched. A behavioural model
//            predicts the ordered stream of framebuffer writes (address,
//            data, ROM address) from the round-robin redraw rules and a
//            synthetic font ROM; a second instance covers address wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_glyph_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digit_val = 16'h1234;
  logic        force_all = 1'b0;

  logic [7:0]  rom_addr;
  logic [7:0]  rom_data = '0;
  logic        fb_we;
  logic [15:0] fb_waddr;
  logic [7:0]  fb_wdata;
  logic        busy;
  logic        frame_done;

  logic [7:0]  wr_rom_addr;
  logic [7:0]  wr_rom_data = '0;
  logic        wr_fb_we;
  logic [15:0] wr_fb_waddr;
  logic [7:0]  wr_fb_wdata;
  logic        wr_busy;
  logic        wr_frame_done;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Captured writes: {addr[15:0], data[7:0], rom_addr[7:0]}
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [23:0] wrap_q[$];
  int          cyc_cnt = 0;
  int          fd_cnt  = 0;
  int          fd_bad  = 0;
  int          wr_fd_cnt = 0;
  logic        prev_busy = 1'b0;

  // Model state
  int          exp_rr = 0;
  logic [3:0]  cur[4];

  always #5 clk = ~clk;

  fb_glyph_sched u_dut (
    .clk        (clk),
    .rst        (rst),
    .digit_val  (digit_val),
    .force_all  (force_all),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .fb_we      (fb_we),
    .fb_waddr   (fb_waddr),
    .fb_wdata   (fb_wdata),
    .busy       (busy),
    .frame_done (frame_done)
  );

  fb_glyph_sched #(.FB_BASE(16'hFFF0), .STRIDE(40)) u_wrap (
    .clk        (clk),
    .rst        (rst),
    .digit_val  (digit_val),
    .force_all  (force_all),
    .rom_addr   (wr_rom_addr),
    .rom_data   (wr_rom_data),
    .fb_we      (wr_fb_we),
    .fb_waddr   (wr_fb_waddr),
    .fb_wdata   (wr_fb_wdata),
    .busy       (wr_busy),
    .frame_done (wr_frame_done)
  );

  // Synthetic font: an odd multiplier makes every address map to a unique byte.
  function automatic logic [7:0] rom_byte(input logic [7:0] a);
    return 8'(a * 8'd29 + 8'd92);
  endfunction

  always @(posedge clk) begin
    rom_data    <= rom_byte(rom_addr);
    wr_rom_data <= rom_byte(wr_rom_addr);
  end

  // Monitor, sampling on the falling edge.
  always @(negedge clk) begin
    cyc_cnt++;
    if (fb_we === 1'b1) begin
      got_q.push_back({fb_waddr, fb_wdata, rom_addr});
      cyc_q.push_back(cyc_cnt);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      if (busy !== 1'b0 || prev_busy !== 1'b1) fd_bad++;
    end
    prev_busy = busy;
    if (wr_fb_we === 1'b1) wrap_q.push_back({wr_fb_waddr, wr_fb_wdata});
    if (wr_frame_done === 1'b1) wr_fd_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expected 16 rows of one digit drawn with glyph g.
  task automatic exp_digit(input int d, input int g);
    logic [7:0]  ra;
    logic [15:0] wa;
    for (int r = 0; r < 16; r++) begin
      ra = 8'(g * 16 + r);
      wa = 16'(d * 2 + r * 40);
      exp_q.push_back({wa, rom_byte(ra), ra});
    end
  endtask

  // One pass over the digits in mask, served in round-robin order from exp_rr.
  task automatic exp_pass(input logic [3:0] mask);
    int last;
    int d;
    last = -1;
    for (int k = 0; k < 4; k++) begin
      d = (exp_rr + k) % 4;
      if (mask[d]) begin
        exp_digit(d, int'(cur[d]));
        last = d;
      end
    end
    if (last >= 0) exp_rr = (last + 1) % 4;
  endtask

  task automatic wait_drain(input int fd0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (fd_cnt > fd0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (6) tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    tick();
    n_tests++; if (fb_we !== 1'b0)       begin n_fail++; $display("FAIL reset_fb_we got %b exp 0", fb_we); end
    n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (frame_done !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    n_tests++; if (rom_addr !== 8'h00)   begin n_fail++; $display("FAIL reset_rom_addr got %h exp 00", rom_addr); end
    n_tests++; if (fb_waddr !== 16'h0)   begin n_fail++; $display("FAIL reset_fb_waddr got %h exp 0000", fb_waddr); end
    n_tests++; if (fb_wdata !== 8'h00)   begin n_fail++; $display("FAIL reset_fb_wdata got %h exp 00", fb_wdata); end
  endtask

  task automatic test_initial_draw();
    int base, fd0, fdb0, lat, gaps;
    bit ok;
    base = got_q.size();
    exp_q.delete();
    exp_rr = 0;
    exp_pass(4'hF);
    fd0  = fd_cnt;
    fdb0 = fd_bad;
    rst  = 1'b0;
    lat  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (fb_we === 1'b1) break;
    end
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL init_latency got %0d exp 3", lat); end
    wait_drain(fd0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL init_drain got timeout exp frame_done"); end
    n_tests++; if (got_q.size() - base !== exp_q.size())
      begin n_fail++; $display("FAIL init_count got %0d exp %0d", got_q.size() - base, exp_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++;
      if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL init_wr[%0d] got %h exp %h", i, got_q[base + i], exp_q[i]);
      end
    end
    gaps = 0;
    for (int i = 1; i < 64; i++) begin
      if (base + i < cyc_q.size() && (i % 16) != 0 && cyc_q[base + i] - cyc_q[base + i - 1] != 2) gaps++;
    end
    n_tests++; if (gaps !== 0) begin n_fail++; $display("FAIL init_row_gaps got %0d exp 0", gaps); end
    n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL init_frame_done got %0d exp 1", fd_cnt - fd0); end
    n_tests++; if (fd_bad !== fdb0) begin n_fail++; $display("FAIL init_busy_fall got %0d bad exp 0", fd_bad - fdb0); end
  endtask

  task automatic test_single_change();
    int base, fd0, after;
    bit ok;
    base = got_q.size();
    exp_q.delete();
    cur[2] = 4'hA;
    exp_pass(4'b0100);
    fd0 = fd_cnt;
    digit_val[11:8] = 4'hA;
    wait_drain(fd0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_drain got timeout exp frame_done"); end
    n_tests++; if (got_q.size() - base !== exp_q.size())
      begin n_fail++; $display("FAIL single_count got %0d exp %0d", got_q.size() - base, exp_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++;
      if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_wr[%0d] got %h exp %h", i, got_q[base + i], exp_q[i]);
      end
    end
    // Shadow now matches, so nothing further gets drawn.
    after = got_q.size();
    repeat (20) tick();
    n_tests++; if (got_q.size() !== after) begin n_fail++; $display("FAIL single_quiet got %0d writes exp 0", got_q.size() - after); end
    n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL single_frame_done got %0d exp 1", fd_cnt - fd0); end
  endtask

  task automatic test_mid_change();
    int base, fd0;
    bit ok, seen;
    base = got_q.size();
    exp_q.delete();
    cur[1] = 4'h7;
    exp_pass(4'b0010);
    fd0 = fd_cnt;
    digit_val[7:4] = 4'h7;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (got_q.size() - base >= 6) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL mid_row5 got timeout exp row 5 write"); end
    digit_val[7:4] = 4'hC;
    cur[1] = 4'hC;
    exp_pass(4'b0010);
    wait_drain(fd0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL mid_drain got timeout exp frame_done"); end
    n_tests++; if (got_q.size() - base !== exp_q.size())
      begin n_fail++; $display("FAIL mid_count got %0d exp %0d", got_q.size() - base, exp_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++;
      if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL mid_wr[%0d] got %h exp %h", i, got_q[base + i], exp_q[i]);
      end
    end
    n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL mid_frame_done got %0d exp 1", fd_cnt - fd0); end
  endtask

  task automatic test_force_all();
    int base, fd0;
    bit ok;
    base = got_q.size();
    exp_q.delete();
    exp_pass(4'hF);
    fd0 = fd_cnt;
    force_all = 1'b1;
    tick();
    force_all = 1'b0;
    wait_drain(fd0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL force_drain got timeout exp frame_done"); end
    n_tests++; if (got_q.size() - base !== exp_q.size())
      begin n_fail++; $display("FAIL force_count got %0d exp %0d", got_q.size() - base, exp_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++;
      if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL force_wr[%0d] got %h exp %h", i, got_q[base + i], exp_q[i]);
      end
    end
    n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL force_frame_done got %0d exp 1", fd_cnt - fd0); end
  endtask

  task automatic test_reset_mid();
    int base, fd0, hold;
    bit ok, seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = got_q.size();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (got_q.size() - base >= 10) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rstmid_10th got timeout exp 10 writes"); end
    rst = 1'b1;
    #1;
    n_tests++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_fb_we got %b exp 0", fb_we); end
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    hold = got_q.size();
    tick();
    n_tests++; if (got_q.size() !== hold) begin n_fail++; $display("FAIL rstmid_no_write got %0d exp 0", got_q.size() - hold); end
    base = got_q.size();
    exp_q.delete();
    exp_rr = 0;
    exp_pass(4'hF);
    fd0 = fd_cnt;
    rst = 1'b0;
    wait_drain(fd0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_drain got timeout exp frame_done"); end
    n_tests++; if (got_q.size() - base !== exp_q.size())
      begin n_fail++; $display("FAIL rstmid_count got %0d exp %0d", got_q.size() - base, exp_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++;
      if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_wr[%0d] got %h exp %h", i, got_q[base + i], exp_q[i]);
      end
    end
    n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL rstmid_frame_done got %0d exp 1", fd_cnt - fd0); end
  endtask

  task automatic test_random();
    int base, fd0;
    bit ok, frc;
    logic [3:0]  mask;
    logic [15:0] nv;
    for (int it = 0; it < 10; it++) begin
      mask = 4'($urandom_range(0, 15));
      frc  = ($urandom_range(0, 3) == 0);
      base = got_q.size();
      exp_q.delete();
      nv = digit_val;
      for (int d = 0; d < 4; d++) begin
        if (mask[d]) begin
          cur[d] = cur[d] ^ 4'($urandom_range(1, 15));
          nv[4*d +: 4] = cur[d];
        end
      end
      exp_pass(frc ? 4'hF : mask);
      fd0 = fd_cnt;
      digit_val = nv;
      force_all = frc;
      tick();
      force_all = 1'b0;
      if (mask == 4'h0 && !frc) begin
        repeat (20) tick();
        n_tests++; if (got_q.size() !== base || fd_cnt !== fd0)
          begin n_fail++; $display("FAIL rand%0d_idle got %0d writes %0d done exp 0 0", it, got_q.size() - base, fd_cnt - fd0); end
      end else begin
        wait_drain(fd0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rand%0d_drain got timeout exp frame_done", it); end
        n_tests++; if (got_q.size() - base !== exp_q.size())
          begin n_fail++; $display("FAIL rand%0d_count got %0d exp %0d", it, got_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
          n_tests++;
          if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) begin
            n_fail++; $display("FAIL rand%0d_wr[%0d] got %h exp %h", it, i, got_q[base + i], exp_q[i]);
          end
        end
        n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL rand%0d_frame_done got %0d exp 1", it, fd_cnt - fd0); end
      end
    end
  endtask

  task automatic test_wrap();
    int fd0, wfd0;
    bit ok, seen;
    logic [7:0] d0;
    rst = 1'b1;
    tick();
    wrap_q.delete();
    fd0  = fd_cnt;
    wfd0 = wr_fd_cnt;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wrap_q.size() >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL wrap_writes got timeout exp 2 writes"); end
    d0 = rom_byte(8'(int'(cur[0]) * 16 + 1));
    n_tests++; if (wrap_q[0][23:8] !== 16'hFFF0)
      begin n_fail++; $display("FAIL wrap_row0_addr got %h exp fff0", wrap_q[0][23:8]); end
    n_tests++; if (wrap_q[1] !== {16'h0018, d0})
      begin n_fail++; $display("FAIL wrap_row1 got %h exp %h", wrap_q[1], {16'h0018, d0}); end
    exp_rr = 0;
    wait_drain(fd0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_drain got timeout exp frame_done"); end
    n_tests++; if (wr_busy !== 1'b0 || wr_fd_cnt - wfd0 !== 1 || wrap_q.size() !== 64)
      begin n_fail++; $display("FAIL wrap_done got busy=%b done=%0d writes=%0d exp 0 1 64", wr_busy, wr_fd_cnt - wfd0, wrap_q.size()); end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) cur[d] = digit_val[4*d +: 4];
    test_reset();
    test_initial_draw();
    test_single_change();
    test_mid_change();
    test_force_all();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
